// File: rtl/sysid_pkg.sv
// Shared constants, register map and helpers for the sysid_regs slave.
// The optional uptime counter is enabled by defining SYSID_UPTIME_EN.
package sysid_pkg;

    typedef logic [31:0] sysid_word_t;

    localparam sysid_word_t SYSID_ADDR_ID       = 32'd0;
    localparam sysid_word_t SYSID_ADDR_TS       = 32'd1;
    localparam sysid_word_t SYSID_ADDR_CAPS     = 32'd2;
    localparam sysid_word_t SYSID_ADDR_UPLO     = 32'd3;
    localparam sysid_word_t SYSID_ADDR_UPHI     = 32'd4;
    localparam sysid_word_t SYSID_ADDR_SCR_BASE = 32'd8;

    localparam logic [7:0] SYSID_VERSION = 8'h02;

    localparam int SYSID_CAPS_NSCR_LSB  = 0;
    localparam int SYSID_CAPS_LAT_LSB   = 4;
    localparam int SYSID_CAPS_VER_LSB   = 8;
    localparam int SYSID_CAPS_UPTIME_BIT = 16;

    function automatic sysid_word_t sysid_caps(
        input int   nscr,
        input int   lat,
        input logic uptime
    );
        sysid_word_t w;
        w = '0;
        w[SYSID_CAPS_NSCR_LSB +: 4] = 4'(nscr);
        w[SYSID_CAPS_LAT_LSB +: 4]  = 4'(lat);
        w[SYSID_CAPS_VER_LSB +: 8]  = SYSID_VERSION;
        w[SYSID_CAPS_UPTIME_BIT]    = uptime;
        return w;
    endfunction

endpackage

// File: rtl/sysid_regs_if.sv
// Avalon-MM bus bundle between the data master and the sysid_regs slave.
// No waitrequest: every request is accepted in the cycle it is presented.
interface sysid_regs_if #(
    parameter int ADDR_W = 4
) ();
    import sysid_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    sysid_word_t       writedata;
    logic [3:0]        byteenable;
    sysid_word_t       readdata;
    logic              readdatavalid;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        output byteenable,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        input  byteenable,
        output readdata,
        output readdatavalid
    );

endinterface

// File: rtl/sysid_rd_pipe.sv
// Fixed-latency read response pipe of {valid, data}, flushed by reset_n.
// Data only advances with a valid beat, so the output holds between responses.
module sysid_rd_pipe
    import sysid_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  sysid_word_t in_data,
    output logic        out_valid,
    output sysid_word_t out_data
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    sysid_word_t      dat_q [DEPTH];
    sysid_word_t      dat_d [DEPTH];

    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_valid;
        dat_d[0] = in_valid ? in_data : dat_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/sysid_regs.sv
// System-identification slave: ID/timestamp/caps, scratch bank, optional uptime.
// Define SYSID_UPTIME_EN to build the 64-bit uptime counter and HI snapshot.
module sysid_regs
    import sysid_pkg::*;
#(
    parameter sysid_word_t ID_VALUE     = 32'h5AD3_1F48,
    parameter sysid_word_t TIMESTAMP    = 32'h0,
    parameter int          ADDR_W       = 4,
    parameter int          READ_LATENCY = 1,
    parameter int          NUM_SCRATCH  = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    sysid_regs_if.slave bus
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
        $error("sysid_regs: READ_LATENCY must be in 1..4");
    end
    if (NUM_SCRATCH < 0 || NUM_SCRATCH > 8) begin : g_bad_scr
        $error("sysid_regs: NUM_SCRATCH must be in 0..8");
    end
    if (ADDR_W < 4) begin : g_bad_aw
        $error("sysid_regs: ADDR_W must be at least 4");
    end

    localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif

    localparam sysid_word_t CAPS_WORD =
        sysid_caps(NUM_SCRATCH, READ_LATENCY, UPTIME_PRESENT);

    sysid_word_t addr;
    logic        rd_en;
    logic        wr_en;

    assign addr  = sysid_word_t'(bus.address);
    assign rd_en = bus.read  && reset_n;
    assign wr_en = bus.write && reset_n;

    // Scratch bank with per-byte write lanes
    sysid_word_t scr_q [SCR_N];
    sysid_word_t scr_d [SCR_N];
    sysid_word_t scr_rd;

    always_comb begin
        scr_rd = '0;
        for (int i = 0; i < SCR_N; i++) begin
            scr_d[i] = scr_q[i];
            if (i < NUM_SCRATCH &&
                addr == SYSID_ADDR_SCR_BASE + sysid_word_t'(i)) begin
                scr_rd = scr_q[i];
                if (wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.byteenable[b]) begin
                            scr_d[i][8*b +: 8] = bus.writedata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < SCR_N; i++) begin
                scr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SCR_N; i++) begin
                scr_q[i] <= scr_d[i];
            end
        end
    end

    sysid_word_t uplo_word;
    sysid_word_t uphi_word;

`ifdef SYSID_UPTIME_EN
    logic [63:0] cnt_q;
    logic [63:0] cnt_d;
    logic [63:0] cnt_inc;
    sysid_word_t snap_q;
    sysid_word_t snap_d;

    // LO read and HI snapshot both see the value the counter takes at this edge
    always_comb begin
        cnt_inc = cnt_q + 64'd1;
        cnt_d   = cnt_inc;
        snap_d  = snap_q;
        if (wr_en && addr == SYSID_ADDR_UPLO) begin
            cnt_d = '0;
        end
        if (rd_en && addr == SYSID_ADDR_UPLO) begin
            snap_d = cnt_inc[63:32];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

    assign uplo_word = cnt_inc[31:0];
    assign uphi_word = snap_q;
`else
    assign uplo_word = '0;
    assign uphi_word = '0;
`endif

    sysid_word_t rd_data;

    always_comb begin
        rd_data = '0;
        case (addr)
            SYSID_ADDR_ID:   rd_data = ID_VALUE;
            SYSID_ADDR_TS:   rd_data = TIMESTAMP;
            SYSID_ADDR_CAPS: rd_data = CAPS_WORD;
            SYSID_ADDR_UPLO: rd_data = uplo_word;
            SYSID_ADDR_UPHI: rd_data = uphi_word;
            default:         rd_data = scr_rd;
        endcase
    end

    sysid_rd_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_rd_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (rd_en),
        .in_data   (rd_data),
        .out_valid (bus.readdatavalid),
        .out_data  (bus.readdata)
    );

endmodule

// File: tb/tb_sysid_regs.sv
// Directed bench for sysid_regs with READ_LATENCY=2, NUM_SCRATCH=2.
// Uptime expectations follow SYSID_UPTIME_EN as defined for the build.
module tb_sysid_regs;
    import sysid_pkg::*;

    localparam sysid_word_t ID_EXP = 32'h5AD3_1F48;
    localparam sysid_word_t TS_EXP = 32'h0;
`ifdef SYSID_UPTIME_EN
    localparam sysid_word_t CAPS_EXP = 32'h0001_0222;
`else
    localparam sysid_word_t CAPS_EXP = 32'h0000_0222;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    sysid_regs_if #(.ADDR_W(4)) bus ();

    sysid_regs #(
        .ID_VALUE     (32'h5AD3_1F48),
        .TIMESTAMP    (32'h0),
        .ADDR_W       (4),
        .READ_LATENCY (2),
        .NUM_SCRATCH  (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input sysid_word_t obs,
                       input sysid_word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input sysid_word_t d,
                      input logic [3:0] be);
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
        bus.write      = 1'b1;
        step();
        bus.write      = 1'b0;
    endtask

    // Read sampled at edge t: valid low after t, high with data after t+1
    task automatic rd(input logic [3:0] a, input sysid_word_t exp,
                      input string tag);
        bus.address = a;
        bus.read    = 1'b1;
        step();
        bus.read    = 1'b0;
        chk({tag, "_gap"}, 32'(bus.readdatavalid), 32'd0);
        step();
        chk({tag, "_vld"}, 32'(bus.readdatavalid), 32'd1);
        chk(tag, bus.readdata, exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        bus.address    = '0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = '0;

        do_reset();
        chk("rst_rdv", 32'(bus.readdatavalid), 32'd0);
        chk("rst_rdata", bus.readdata, 32'd0);

        rd(4'd0, ID_EXP, "id");
        step();
        chk("pulse_once", 32'(bus.readdatavalid), 32'd0);
        chk("hold_rdata", bus.readdata, ID_EXP);

        // Back-to-back reads of words 0,1,2
        bus.address = 4'd0;
        bus.read    = 1'b1;
        step();
        bus.address = 4'd1;
        step();
        chk("b2b0_vld", 32'(bus.readdatavalid), 32'd1);
        chk("b2b0", bus.readdata, ID_EXP);
        bus.address = 4'd2;
        step();
        bus.read    = 1'b0;
        chk("b2b1_vld", 32'(bus.readdatavalid), 32'd1);
        chk("b2b1", bus.readdata, TS_EXP);
        step();
        chk("b2b2_vld", 32'(bus.readdatavalid), 32'd1);
        chk("b2b2", bus.readdata, CAPS_EXP);
        step();
        chk("b2b_end", 32'(bus.readdatavalid), 32'd0);

        wr(4'd8, 32'hA5A5_A5A5, 4'hF);
        wr(4'd8, 32'h0000_1234, 4'h3);
        rd(4'd8, 32'hA5A5_1234, "scr_lanes");
        wr(4'd9, 32'h0000_0001, 4'hF);
        wr(4'd9, 32'hFFFF_FF00, 4'h4);
        rd(4'd9, 32'h00FF_0001, "scr_lane2");
        rd(4'd10, 32'd0, "scr_oor10");
        rd(4'd15, 32'd0, "scr_oor15");
        rd(4'd5, 32'd0, "unmapped5");

        // Same-cycle read and write of word 9 returns the old value
        wr(4'd9, 32'h0000_0001, 4'hF);
        bus.address    = 4'd9;
        bus.writedata  = 32'h0000_0002;
        bus.byteenable = 4'hF;
        bus.read       = 1'b1;
        bus.write      = 1'b1;
        step();
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        step();
        chk("rw_same_vld", 32'(bus.readdatavalid), 32'd1);
        chk("rw_same_old", bus.readdata, 32'h0000_0001);
        rd(4'd9, 32'h0000_0002, "rw_new");

        // Uptime: last reset edge is r; a read sampled at r+100 returns 100
        do_reset();
        repeat (99) step();
`ifdef SYSID_UPTIME_EN
        rd(4'd3, 32'd100, "uplo_100");
        rd(4'd4, 32'd0, "uphi_0");
        wr(4'd3, 32'hDEAD_BEEF, 4'h0);
        rd(4'd3, 32'd1, "uplo_clr");
`else
        rd(4'd3, 32'd0, "uplo_off");
        rd(4'd4, 32'd0, "uphi_off");
        wr(4'd3, 32'hDEAD_BEEF, 4'hF);
        rd(4'd3, 32'd0, "uplo_off_wr");
`endif
        rd(4'd8, 32'd0, "scr_rst");

        // Reset arriving one edge after a read flushes it
        wr(4'd9, 32'h0000_0002, 4'hF);
        rd(4'd9, 32'h0000_0002, "pre_flush");
        bus.address = 4'd0;
        bus.read    = 1'b1;
        step();
        bus.read    = 1'b0;
        reset_n     = 1'b0;
        step();
        reset_n     = 1'b1;
        chk("flush_rdv_t1", 32'(bus.readdatavalid), 32'd0);
        chk("flush_rdata", bus.readdata, 32'd0);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk($sformatf("flush_rdv_t%0d", k),
                32'(bus.readdatavalid), 32'd0);
        end
        chk("flush_rdata_end", bus.readdata, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysid_regs.md
# sysid_regs

Parametrised Avalon-MM system-identification slave and successor to the single-word sysid peripheral. It exposes a read-only ID, build timestamp and capability word, an optional 64-bit uptime counter with atomic high-word snapshot, and a bank of byte-writable scratch registers. All reads use a fixed, configurable read latency with `readdatavalid`. It sits on the SOPC data master as the `control_slave` that software probes first at boot.

## Interface
Parameters:
- `ID_VALUE`, 32'h5AD3_1F48: system ID returned at word 0.
- `TIMESTAMP`, 32'h0: build timestamp returned at word 1.
- `ADDR_W`, 4: word-address width; must be ≥4.
- `READ_LATENCY`, 1: read cycles from `read` to `readdatavalid`; legal range 1..4.
- `NUM_SCRATCH`, 2: scratch register count; legal range 0..8.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `address` in ADDR_W: word address.
- `read` in 1: read request; one request per asserted cycle.
- `write` in 1: write request.
- `writedata` in 32: write data.
- `byteenable` in 4: write byte lanes.
- `readdata` out 32: read data, valid when `readdatavalid` is high.
- `readdatavalid` out 1: one-cycle pulse per accepted read.

## Operation
Register map (word addresses):
- 0 ID: RO, `ID_VALUE`.
- 1 TIMESTAMP: RO, `TIMESTAMP`.
- 2 CAPS: RO. [3:0] `NUM_SCRATCH`; [7:4] `READ_LATENCY`; [15:8] version 8'h02; [16] uptime present; [31:17] 0.
- 3 UPTIME_LO: a read returns counter[31:0] and latches counter[63:32] into the HI snapshot in the same cycle. Any write clears the counter; byteenable is ignored.
- 4 UPTIME_HI: RO, returns the snapshot.
- 8..8+NUM_SCRATCH-1: scratch registers, R/W, with per-byte `byteenable`.
- All other addresses: reads return 0; writes are ignored.

Behaviour:
- No `waitrequest`. Every read and write is accepted in the cycle it is presented.
- Uptime counter: 64 bits, increments by 1 every cycle and wraps from 2^64-1 to 0. A clear takes priority over the increment, so the value is 0 in the next cycle.
- `read` and `write` in the same cycle: both take effect. The read returns the pre-write value.
- Read-after-write on the next cycle returns the new value.
- Reads above the implemented scratch range return 0, even at addresses in 8..15.
- Out-of-range `READ_LATENCY`, `NUM_SCRATCH` or `ADDR_W` raises an elaboration-time `$error`.

## Timing
- A read sampled at edge t produces `readdatavalid`=1 and its data at edge t+READ_LATENCY, for exactly one cycle.
- Reads may be issued back-to-back. Responses return in order, one per cycle, with no gaps.
- `readdata` holds its last value while `readdatavalid`=0.
- Reset (`reset_n`=0 at an edge):
  - `readdata`=0, `readdatavalid`=0, counter=0, snapshot=0, scratch=0.
  - The whole read pipeline is flushed, so in-flight reads never produce `readdatavalid`.
- A read or write presented in a reset cycle is ignored.
- Register data is sampled at request time, not at response time. For UPTIME_LO, the value returned is the counter at edge t.

## Configuration
- `SYSID_UPTIME_EN` defined: counter and snapshot are built; CAPS[16]=1.
- `SYSID_UPTIME_EN` undefined: no counter or snapshot flops; words 3 and 4 read 0; writes to 3 are ignored; CAPS[16]=0.

## Structure
- Package `sysid_pkg`:
  - Address constants `SYSID_ADDR_ID`, `_TS`, `_CAPS`, `_UPLO`, `_UPHI`, `_SCR_BASE` (=8).
  - `SYSID_VERSION` (8'h02).
  - CAPS bit-field localparams.
  - Typedef `sysid_word_t` (logic [31:0]).
- One sub-module, `sysid_rd_pipe`: a parametrised depth-READ_LATENCY shift register of {valid, data} with a synchronous flush on `reset_n`.
- The top level holds the decode, scratch bank and counter.

## Test plan
- Reset, with `READ_LATENCY`=2: read addr 0 at edge t → `readdatavalid`=1 at t+2 only, `readdata`=32'h5AD3_1F48.
- Back-to-back reads of addrs 0,1,2, with `NUM_SCRATCH`=2, `READ_LATENCY`=2 and the macro on → three consecutive valids: ID, TIMESTAMP, 32'h0001_0222.
- Scratch byte lanes:
  - Write 32'hA5A5_A5A5 to addr 8 with be=4'hF, then 32'h0000_1234 with be=4'h3, then read addr 8 → 32'hA5A5_1234.
  - Read of addr 10 (beyond `NUM_SCRATCH`) → 0.
- Uptime:
  - Read LO 100 cycles after reset → 32'd99 or 32'd100, per the exact edge count documented in the bench; HI read → 0.
  - Write addr 3, then read LO on the next cycle → 1.
  - Macro off: words 3 and 4 read 0 and CAPS[16]=0.
- Reset mid-read, with `READ_LATENCY`=3: read at t, `reset_n`=0 at t+1 → no `readdatavalid` through t+5; `readdata`=0.
- Read and write of addr 9 in the same cycle, old value 32'h1, new value 32'h2 → response 32'h1; next read → 32'h2.
